// File: rtl/urna_pkg.sv
// Shared types and constants for the URNA voting session controller.
package urna_pkg;

  // Session sequencer states.
  typedef enum logic [3:0] {
    INIT,
    IDLE,
    ARMED,
    SEND,
    G1,
    G2,
    HOLD,
    NEXT,
    CLOSED,
    CLEAR
  } state_t;

  // Digit value that the tally cannot match, so it takes its null path.
  localparam logic [3:0] NULL_DIGIT = 4'hF;

  // The tally always resolves a vote within this many digits.
  localparam int DIGITS_PER_VOTE = 4;

  // Largest keypad code that is a real digit.
  localparam logic [3:0] MAX_KEY = 4'd9;

  // True when a keypad code is a digit the tally understands.
  function automatic logic key_is_digit(input logic [3:0] code);
    return code <= MAX_KEY;
  endfunction

endpackage

// File: rtl/urna_session_ctrl_if.sv
// Panel/tally signal bundle for the session controller.
// master: the controller side. slave: the keypad, panel and tally side.
interface urna_session_ctrl_if;

  // Poll-worker panel and keypad
  logic       Authorize;
  logic       CloseReq;
  logic       ClearReq;
  logic       KeyStrobe;
  logic [3:0] KeyCode;

  // Tally status (StatusNulo is active-low)
  logic       StatusValido;
  logic       StatusNulo;

  // Tally commands
  logic [3:0] Digit;
  logic       Valid;
  logic       Next;
  logic       Finish;

  // Panel status
  logic [7:0] VoterCount;
  logic       Ready;
  logic       Busy;
  logic       Closed;
  logic       Full;
  logic       KeyError;

  modport master (
    input  Authorize, CloseReq, ClearReq, KeyStrobe, KeyCode,
    input  StatusValido, StatusNulo,
    output Digit, Valid, Next, Finish,
    output VoterCount, Ready, Busy, Closed, Full, KeyError
  );

  modport slave (
    output Authorize, CloseReq, ClearReq, KeyStrobe, KeyCode,
    output StatusValido, StatusNulo,
    input  Digit, Valid, Next, Finish,
    input  VoterCount, Ready, Busy, Closed, Full, KeyError
  );

endinterface

// File: rtl/urna_timer.sv
// Loadable down-counter. While load_i is high the counter is parked at
// CYCLES-1; once released it counts down while en_i is high, so done_o rises
// in the CYCLES-th enabled cycle after the load is released.
module urna_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] count_q;

  // Reload, or count down towards zero and stop there.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= LOAD_VAL;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/urna_session_ctrl.sv
// Voter session controller: gates the tally on poll-worker authorisation,
// forwards keypad digits as one-cycle Valid strobes, watches the tally
// status, holds the result, then issues Next. Also handles inactivity
// timeout, poll closing and clearing of the totals (Finish).
module urna_session_ctrl
  import urna_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 8,
  parameter int MAX_VOTERS     = 255
) (
  input  logic                Clock,
  input  logic                Reset,
  urna_session_ctrl_if.master bus
);

  localparam int         DCW       = $clog2(DIGITS_PER_VOTE + 1);
  localparam logic [7:0] MAX_COUNT = 8'(MAX_VOTERS);

  state_t           state_q;
  logic [3:0]       digit_q;
  logic             valid_q;
  logic             next_q;
  logic             finish_q;
  logic             key_error_q;
  logic             busy_q;
  logic             closed_q;
  logic             ready_q;
  logic [7:0]       voter_count_q;
  logic [7:0]       voter_count_d;
  logic [DCW-1:0]   digit_cnt_q;

  logic             full;
  logic             status_hit;
  logic             inact_done;
  logic             hold_done;

  assign full          = (voter_count_q == MAX_COUNT);
  assign voter_count_d = full ? voter_count_q : voter_count_q + 8'd1;
  // The tally reports a counted vote either as valid or as null (active-low).
  assign status_hit    = bus.StatusValido || !bus.StatusNulo;

  // Inactivity timer: parked outside ARMED, so every entry to ARMED restarts
  // it, while a rejected key (which stays in ARMED) leaves it running.
  urna_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_inact_timer (
    .clk_i  (Clock),
    .srst_i (Reset),
    .load_i (state_q != ARMED),
    .en_i   (state_q == ARMED),
    .done_o (inact_done)
  );

  // Result hold timer: parked outside HOLD, runs for HOLD_CYCLES in HOLD.
  urna_timer #(
    .CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk_i  (Clock),
    .srst_i (Reset),
    .load_i (state_q != HOLD),
    .en_i   (state_q == HOLD),
    .done_o (hold_done)
  );

  // Session sequencer with registered outputs; pulses default low each cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= INIT;
      digit_q       <= '0;
      valid_q       <= 1'b0;
      next_q        <= 1'b1;   // INIT realigns the tally, which has no reset
      finish_q      <= 1'b0;
      key_error_q   <= 1'b0;
      busy_q        <= 1'b0;
      closed_q      <= 1'b0;
      ready_q       <= 1'b0;
      voter_count_q <= '0;
      digit_cnt_q   <= '0;
    end else begin
      valid_q     <= 1'b0;
      next_q      <= 1'b0;
      finish_q    <= 1'b0;
      key_error_q <= 1'b0;

      case (state_q)
        INIT: begin
          state_q <= IDLE;
          ready_q <= !full;
        end

        IDLE: begin
          // Close has priority over everything else presented in IDLE.
          if (bus.CloseReq) begin
            state_q  <= CLOSED;
            closed_q <= 1'b1;
            ready_q  <= 1'b0;
          end else if (bus.ClearReq) begin
            state_q  <= CLEAR;
            finish_q <= 1'b1;
            ready_q  <= 1'b0;
          end else if (bus.Authorize && !full) begin
            state_q     <= ARMED;
            digit_cnt_q <= '0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
          end
        end

        ARMED: begin
          if (bus.KeyStrobe && key_is_digit(bus.KeyCode)) begin
            state_q <= SEND;
            digit_q <= bus.KeyCode;
            valid_q <= 1'b1;
          end else begin
            if (bus.KeyStrobe) begin
              key_error_q <= 1'b1;
            end
            // Voter walked away: push a digit that forces a null vote.
            if (inact_done) begin
              state_q <= SEND;
              digit_q <= NULL_DIGIT;
              valid_q <= 1'b1;
            end
          end
        end

        SEND: begin
          state_q     <= G1;
          digit_cnt_q <= digit_cnt_q + DCW'(1);
        end

        G1: state_q <= G2;

        // The tally's verdict for the last digit is visible here.
        G2: state_q <= status_hit ? HOLD : ARMED;

        HOLD: begin
          if (hold_done) begin
            state_q <= NEXT;
            next_q  <= 1'b1;
          end
        end

        NEXT: begin
          state_q       <= IDLE;
          voter_count_q <= voter_count_d;
          busy_q        <= 1'b0;
          ready_q       <= (voter_count_d != MAX_COUNT);
        end

        CLOSED: begin
          if (bus.ClearReq) begin
            state_q  <= CLEAR;
            finish_q <= 1'b1;
          end
        end

        CLEAR: begin
          state_q       <= IDLE;
          voter_count_q <= '0;
          closed_q      <= 1'b0;
          ready_q       <= (MAX_COUNT != 8'd0);
        end

        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.Digit      = digit_q;
  assign bus.Valid      = valid_q;
  assign bus.Next       = next_q;
  assign bus.Finish     = finish_q;
  assign bus.VoterCount = voter_count_q;
  assign bus.Ready      = ready_q;
  assign bus.Busy       = busy_q;
  assign bus.Closed     = closed_q;
  assign bus.Full       = full;
  assign bus.KeyError   = key_error_q;

  // A vote resolves within DIGITS_PER_VOTE digits, so ARMED never sees a full counter.
  a_digit_limit : assert property (@(posedge Clock) disable iff (Reset)
    (state_q == ARMED) |-> (digit_cnt_q != DCW'(DIGITS_PER_VOTE)));

  // The three tally commands are mutually exclusive.
  a_one_command : assert property (@(posedge Clock)
    $onehot0({valid_q, next_q, finish_q}));

endmodule

// File: tb/tb_urna_session_ctrl.sv
// Directed bench for urna_session_ctrl with a small behavioural vote tally.
module tb_urna_session_ctrl;

  localparam int TO_CYC   = 20;
  localparam int HOLD_CYC = 4;
  localparam int MAXV     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  urna_session_ctrl_if bus ();

  urna_session_ctrl #(
    .TIMEOUT_CYCLES (TO_CYC),
    .HOLD_CYCLES    (HOLD_CYC),
    .MAX_VOTERS     (MAXV)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // ---------------- Tally model ----------------
  // Four candidate codes; a digit that matches no remaining candidate makes
  // the vote null. The verdict appears two cycles after Valid (in G2).
  logic [15:0] cand [4] = '{16'h3494, 16'h3485, 16'h3477, 16'h3504};
  int          t_pos   = 0;
  logic [3:0]  t_alive = 4'hF;
  logic        t_vld   = 1'b0;
  logic [3:0]  t_dig   = 4'h0;
  int          tc [4]  = '{0, 0, 0, 0};
  int          tnulo   = 0;

  always @(posedge clk) begin
    logic [3:0] m;
    bus.StatusValido <= 1'b0;
    bus.StatusNulo   <= 1'b1;
    t_vld <= bus.Valid;
    t_dig <= bus.Digit;
    if (bus.Next === 1'b1) begin
      t_pos   <= 0;
      t_alive <= 4'hF;
    end else if (t_vld) begin
      m = t_alive;
      for (int i = 0; i < 4; i++)
        if (cand[i][15-4*t_pos -: 4] != t_dig) m[i] = 1'b0;
      if (m == 4'h0) begin
        tnulo <= tnulo + 1;
        bus.StatusNulo <= 1'b0;
      end else if (t_pos == 3) begin
        for (int i = 0; i < 4; i++) if (m[i]) tc[i] <= tc[i] + 1;
        bus.StatusValido <= 1'b1;
      end else begin
        t_pos   <= t_pos + 1;
        t_alive <= m;
      end
    end
    if (bus.Finish === 1'b1) begin
      tnulo <= 0;
      for (int i = 0; i < 4; i++) tc[i] <= 0;
    end
  end

  // ---------------- Output monitor ----------------
  int         cyc = 0;
  int         valid_cnt = 0, next_cnt = 0, finish_cnt = 0, kerr_cnt = 0, overlap = 0;
  logic [3:0] vdig [$];
  int         vcyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.Valid === 1'b1) begin
      valid_cnt++;
      vdig.push_back(bus.Digit);
      vcyc.push_back(cyc);
    end
    if (bus.Next === 1'b1) next_cnt++;
    if (bus.Finish === 1'b1) finish_cnt++;
    if (bus.KeyError === 1'b1) kerr_cnt++;
    if ((int'(bus.Valid === 1'b1) + int'(bus.Next === 1'b1) + int'(bus.Finish === 1'b1)) > 1)
      overlap++;
  end

  // ---------------- Checking helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_auth();
    bus.Authorize = 1'b1;
    tick();
    bus.Authorize = 1'b0;
  endtask

  // One key press, then wait out SEND/G1/G2 so the next key lands in ARMED.
  task automatic press(input logic [3:0] code);
    bus.KeyStrobe = 1'b1;
    bus.KeyCode   = code;
    tick();
    bus.KeyStrobe = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic wait_next(input int old, input string name);
    int n = 0;
    while (next_cnt == old && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_next_pulse"}, next_cnt - old, 1);
  endtask

  function automatic logic [19:0] tally_now();
    return {tc[0][3:0], tc[1][3:0], tc[2][3:0], tc[3][3:0], tnulo[3:0]};
  endfunction

  function automatic logic [19:0] tally_exp(input int res);
    return (res == 0) ? 20'h00001 : (20'h00001 << (4 * (5 - res)));
  endfunction

  task automatic clear_totals(input string name);
    int f0 = finish_cnt;
    bus.ClearReq = 1'b1;
    tick();
    bus.ClearReq = 1'b0;
    chk({name, "_finish_hi"}, bus.Finish, 1);
    tick();
    chk({name, "_finish_once"}, finish_cnt - f0, 1);
    chk({name, "_count_zero"}, bus.VoterCount, 0);
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    string      name;
    int         nkeys;
    logic [3:0] keys [4];
    int         exp_valids;
    int         exp_res;     // 1..4 = candidate counted, 0 = null
  } vec_t;

  vec_t vecs [7];

  function automatic void set_vec(input int i, input string nm, input int n,
                                  input logic [15:0] ks, input int ev, input int er);
    vecs[i].name       = nm;
    vecs[i].nkeys      = n;
    for (int j = 0; j < 4; j++) vecs[i].keys[j] = ks[15-4*j -: 4];
    vecs[i].exp_valids = ev;
    vecs[i].exp_res    = er;
  endfunction

  // ---------------- Main sequence ----------------
  initial begin
    int v0, q0, n0, f0, k0;
    logic [15:0] ed, ad;

    set_vec(0, "vote_c1",       4, 16'h3494, 4, 1);
    set_vec(1, "null_key2",     3, 16'h3170, 2, 0);  // key 7 lands in HOLD
    set_vec(2, "vote_c4",       4, 16'h3504, 4, 4);
    set_vec(3, "vote_c2",       4, 16'h3485, 4, 2);
    set_vec(4, "vote_c3",       4, 16'h3477, 4, 3);
    set_vec(5, "null_key1",     1, 16'h5000, 1, 0);
    set_vec(6, "null_key4",     4, 16'h3499, 4, 0);

    bus.Authorize = 1'b0;
    bus.CloseReq  = 1'b0;
    bus.ClearReq  = 1'b0;
    bus.KeyStrobe = 1'b0;
    bus.KeyCode   = 4'h0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // First cycle after reset: INIT with Next high.
    chk("rst_next", bus.Next, 1);
    chk("rst_valid", bus.Valid, 0);
    chk("rst_digit", bus.Digit, 0);
    chk("rst_count", bus.VoterCount, 0);
    chk("rst_busy_closed", {bus.Busy, bus.Closed, bus.Finish, bus.KeyError}, 0);
    tick();
    chk("init_next_low", bus.Next, 0);
    chk("init_ready", bus.Ready, 1);

    // Table-driven sessions, totals cleared after each.
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt; q0 = vdig.size(); n0 = next_cnt;
      do_auth();
      chk({vecs[i].name, "_busy"}, {bus.Busy, bus.Ready}, 2'b10);
      for (int j = 0; j < vecs[i].nkeys; j++) press(vecs[i].keys[j]);
      wait_next(n0, vecs[i].name);
      chk({vecs[i].name, "_valids"}, valid_cnt - v0, vecs[i].exp_valids);
      ed = '0; ad = '0;
      for (int j = 0; j < vecs[i].exp_valids; j++) begin
        ed = {ed[11:0], vecs[i].keys[j]};
        ad = {ad[11:0], (q0 + j < vdig.size()) ? vdig[q0+j] : 4'h0};
      end
      chk({vecs[i].name, "_digits"}, ad, ed);
      chk({vecs[i].name, "_tally"}, tally_now(), tally_exp(vecs[i].exp_res));
      chk({vecs[i].name, "_count"}, bus.VoterCount, 1);
      chk({vecs[i].name, "_ready"}, bus.Ready, 1);
      clear_totals(vecs[i].name);
    end

    // Inactivity timeout after one digit forces a null digit.
    v0 = valid_cnt; q0 = vdig.size(); n0 = next_cnt;
    do_auth();
    press(4'd3);
    wait_next(n0, "timeout");
    chk("timeout_valids", valid_cnt - v0, 2);
    chk("timeout_null_digit", (q0 + 1 < vdig.size()) ? vdig[q0+1] : 4'h0, 4'hF);
    chk("timeout_gap", (q0 + 1 < vcyc.size()) ? vcyc[q0+1] - vcyc[q0] : 0, TO_CYC + 3);
    chk("timeout_tally", tally_now(), 20'h00001);
    chk("timeout_count", bus.VoterCount, 1);
    clear_totals("timeout");

    // Rejected key code, then a valid vote for C4.
    v0 = valid_cnt; n0 = next_cnt; k0 = kerr_cnt;
    do_auth();
    bus.KeyStrobe = 1'b1; bus.KeyCode = 4'hA;
    tick();
    bus.KeyStrobe = 1'b0;
    chk("keyerr_pulse", bus.KeyError, 1);
    tick();
    chk("keyerr_one_cycle", bus.KeyError, 0);
    chk("keyerr_no_valid", valid_cnt - v0, 0);
    press(4'd3); press(4'd5); press(4'd0); press(4'd4);
    wait_next(n0, "keyerr");
    chk("keyerr_count", kerr_cnt - k0, 1);
    chk("keyerr_tally", tally_now(), 20'h00010);
    // A bad key while IDLE is dropped silently.
    bus.KeyStrobe = 1'b1; bus.KeyCode = 4'hB;
    tick();
    bus.KeyStrobe = 1'b0;
    chk("idle_key_silent", bus.KeyError, 0);
    clear_totals("keyerr");

    // Close wins over Authorize; CLOSED ignores Authorize and keys; Clear reopens.
    n0 = next_cnt;
    do_auth();
    press(4'd3); press(4'd4); press(4'd9); press(4'd4);
    wait_next(n0, "preclose");
    bus.CloseReq = 1'b1; bus.Authorize = 1'b1;
    tick();
    bus.CloseReq = 1'b0; bus.Authorize = 1'b0;
    chk("close_state", {bus.Closed, bus.Busy, bus.Ready}, 3'b100);
    k0 = kerr_cnt;
    bus.Authorize = 1'b1; bus.KeyStrobe = 1'b1; bus.KeyCode = 4'hC;
    tick();
    bus.Authorize = 1'b0; bus.KeyStrobe = 1'b0;
    tick();
    chk("closed_ignores", {bus.Closed, bus.Busy}, 2'b10);
    chk("closed_no_keyerr", kerr_cnt - k0, 0);
    chk("closed_tally_kept", tally_now(), 20'h10000);
    f0 = finish_cnt;
    bus.ClearReq = 1'b1;
    tick();
    bus.ClearReq = 1'b0;
    chk("clear_finish_hi", bus.Finish, 1);
    tick();
    chk("clear_finish_once", finish_cnt - f0, 1);
    chk("clear_state", {bus.Closed, bus.Ready, bus.Finish}, 3'b010);
    chk("clear_count", bus.VoterCount, 0);
    chk("clear_tally", tally_now(), 20'h00000);

    // Reset mid-session, with Close/Clear attempted in ARMED (ignored).
    f0 = finish_cnt;
    do_auth();
    press(4'd3); press(4'd4);
    bus.CloseReq = 1'b1; bus.ClearReq = 1'b1;
    tick();
    bus.CloseReq = 1'b0; bus.ClearReq = 1'b0;
    chk("armed_ignores_close", {bus.Closed, bus.Busy}, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_next", bus.Next, 1);
    chk("midrst_busy", bus.Busy, 0);
    tick();
    n0 = next_cnt;
    do_auth();
    press(4'd3); press(4'd4); press(4'd8); press(4'd5);
    wait_next(n0, "midrst");
    chk("midrst_tally", tally_now(), 20'h01000);
    chk("midrst_count", bus.VoterCount, 1);
    chk("armed_no_finish", finish_cnt - f0, 0);

    // Fill to MAX_VOTERS with short null sessions; Authorize is then ignored.
    for (int s = 0; s < MAXV - 1; s++) begin
      n0 = next_cnt;
      do_auth();
      press(4'd6);
      wait_next(n0, "fill");
    end
    chk("full_count", bus.VoterCount, MAXV);
    chk("full_flags", {bus.Full, bus.Ready}, 2'b10);
    do_auth();
    tick();
    chk("full_auth_ignored", bus.Busy, 0);

    chk("strobe_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
